// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions: condition check,
// operand fetch over one shared RF read port, shifter/ALU drive, then writeback.
module dp_sequencer #(
    parameter logic [31:0] PC_READ_OFS    = 32'd8,
    parameter logic [31:0] PC_READ_OFS_RS = 32'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [3:0]  cpsr_nzcv,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] sh_value,
    output logic [7:0]  sh_amount,
    output logic [1:0]  sh_type,
    output logic        sh_imm,
    input  logic [31:0] sh_result,
    input  logic        sh_carry,
    output logic [3:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_nzcv,
    output logic        alu_sc,
    input  logic [31:0] alu_out,
    input  logic [1:0]  alu_cv,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flags_we,
    output logic [3:0]  flags_out,
    output logic        spsr_restore,
    output logic        branch,
    output logic [31:0] branch_target
);

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  fixed;
        logic        imm_op;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] op2;
    } dp_instr_t;

    typedef enum logic [2:0] {
        S_IDLE, S_COND, S_RD_RN, S_RD_RM, S_RD_RS, S_EXEC, S_WB
    } state_t;

    state_t    state, next_state;
    dp_instr_t ins_q;
    logic [31:0] pc_q, rn_q, rm_q, res_q;
    logic [3:0]  nzcv_q;
    logic [7:0]  rs_q;
    logic [1:0]  cv_q;
    logic        sc_q;

    logic        is_mov, writes, reg_shift, rd_pc, cond_pass;
    logic [31:0] pc_std, pc_rs, pc_opnd;
    logic [3:0]  rm_idx, rs_idx;
    logic        unused_bits;

    assign rm_idx    = ins_q.op2[3:0];
    assign rs_idx    = ins_q.op2[11:8];
    assign is_mov    = (ins_q.opcode == 4'hD) || (ins_q.opcode == 4'hF);
    assign writes    = (ins_q.opcode[3:2] != 2'b10);
    assign reg_shift = !ins_q.imm_op && ins_q.op2[4];
    assign rd_pc     = writes && (ins_q.rd == 4'hF);
    assign pc_std    = pc_q + PC_READ_OFS;
    assign pc_rs     = pc_q + PC_READ_OFS_RS;
    // r15 as Rn/Rm reads further ahead when the shift amount comes from Rs
    assign pc_opnd   = reg_shift ? pc_rs : pc_std;
    assign unused_bits = ^ins_q.fixed;

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = nzcv_q;
        cond_pass = 1'b0;
        case (ins_q.cond)
            4'h0: cond_pass = z;
            4'h1: cond_pass = !z;
            4'h2: cond_pass = c;
            4'h3: cond_pass = !c;
            4'h4: cond_pass = n;
            4'h5: cond_pass = !n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = !v;
            4'h8: cond_pass = c && !z;
            4'h9: cond_pass = !c || z;
            4'hA: cond_pass = (n == v);
            4'hB: cond_pass = (n != v);
            4'hC: cond_pass = !z && (n == v);
            4'hD: cond_pass = z || (n != v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_COND;
            S_COND: begin
                if (!cond_pass)  next_state = S_WB;
                else if (is_mov) next_state = ins_q.imm_op ? S_EXEC : S_RD_RM;
                else             next_state = S_RD_RN;
            end
            S_RD_RN: next_state = ins_q.imm_op ? S_EXEC : S_RD_RM;
            S_RD_RM: next_state = ins_q.op2[4] ? S_RD_RS : S_EXEC;
            S_RD_RS: next_state = S_EXEC;
            S_EXEC:  next_state = S_WB;
            S_WB:    next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_q  <= '0;
            pc_q   <= '0;
            nzcv_q <= '0;
            rn_q   <= '0;
            rm_q   <= '0;
            rs_q   <= '0;
            res_q  <= '0;
            cv_q   <= '0;
            sc_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ins_q  <= instr;
                    pc_q   <= pc;
                    nzcv_q <= cpsr_nzcv;
                    rn_q   <= '0;   // MOV/MVN leave operand A at zero
                end
                S_RD_RN: rn_q <= (ins_q.rn == 4'hF) ? pc_opnd : rf_rdata;
                S_RD_RM: rm_q <= (rm_idx == 4'hF) ? pc_opnd : rf_rdata;
                S_RD_RS: rs_q <= (rs_idx == 4'hF) ? pc_rs[7:0] : rf_rdata[7:0];
                S_EXEC: begin
                    res_q <= alu_out;
                    cv_q  <= alu_cv;
                    sc_q  <= sh_carry;
                end
                default: ;
            endcase
        end
    end

    assign alu_opcode = ins_q.opcode;
    assign alu_nzcv   = nzcv_q;
    assign alu_sc     = sc_q;

    always_comb begin
        busy          = (state != S_IDLE);
        done          = 1'b0;
        rf_raddr      = 4'h0;
        sh_value      = 32'h0;
        sh_amount     = 8'h0;
        sh_type       = 2'b00;
        sh_imm        = 1'b0;
        alu_a         = 32'h0;
        alu_b         = 32'h0;
        rf_we         = 1'b0;
        rf_waddr      = 4'h0;
        rf_wdata      = 32'h0;
        flags_we      = 1'b0;
        flags_out     = 4'h0;
        spsr_restore  = 1'b0;
        branch        = 1'b0;
        branch_target = 32'h0;
        case (state)
            S_RD_RN: rf_raddr = (ins_q.rn == 4'hF) ? 4'h0 : ins_q.rn;
            S_RD_RM: rf_raddr = (rm_idx == 4'hF) ? 4'h0 : rm_idx;
            S_RD_RS: rf_raddr = (rs_idx == 4'hF) ? 4'h0 : rs_idx;
            S_EXEC: begin
                if (ins_q.imm_op) begin
                    sh_value  = {24'h0, ins_q.op2[7:0]};
                    sh_amount = {3'b000, ins_q.op2[11:8], 1'b0};
                    sh_type   = 2'b11;
                end else begin
                    sh_value  = rm_q;
                    sh_amount = ins_q.op2[4] ? rs_q : {3'b000, ins_q.op2[11:7]};
                    sh_type   = ins_q.op2[6:5];
                    sh_imm    = !ins_q.op2[4];
                end
                alu_a = rn_q;
                alu_b = sh_result;
            end
            S_WB: begin
                done          = 1'b1;
                rf_waddr      = ins_q.rd;
                rf_wdata      = res_q;
                branch_target = {res_q[31:2], 2'b00};
                flags_out     = {res_q[31], (res_q == 32'h0), cv_q};
                if (cond_pass) begin
                    rf_we        = writes && !rd_pc;
                    branch       = rd_pc;
                    flags_we     = ins_q.s && !rd_pc;
                    spsr_restore = ins_q.s && rd_pc;
                end
            end
            default: ;
        endcase
    end

endmodule
